// File: rtl/me_search_sequencer_if.sv
// Control/address bundle between the search sequencer and the systolic ME datapath.
// Widths are derived from the block edge and the search-window edge.
interface me_search_sequencer_if #(
  parameter int BLK_N = 16,
  parameter int SW_W  = 31
);
  localparam int CAND_COLS = SW_W - BLK_N + 1;
  localparam int CW        = (CAND_COLS > 1) ? $clog2(CAND_COLS) : 1;
  localparam int RB_AW     = $clog2(BLK_N * BLK_N);
  localparam int SW_AW     = $clog2(SW_W * SW_W);

  // Handshake: a sweep is accepted on an edge with in_start & in_cu_ena high
  // while idle; an address set is presented while out_addr_vld is high and
  // is consumed by every edge with in_cu_ena high (low = stall, all holds).
  logic             in_cu_ena;
  logic             in_start;
  logic             out_busy;
  logic             out_done;
  logic             out_addr_vld;
  logic             out_pass_last;
  logic [CW-1:0]    out_cand_col;
  logic [RB_AW-1:0] out_rb_read_addr;
  logic [SW_AW-1:0] out_sw_read_addr1;
  logic [SW_AW-1:0] out_sw_read_addr2;
  logic [BLK_N-1:0] out_pe_ena;
  logic [BLK_N-1:0] out_sw_mux;
  logic [1:0]       dbg_state;

  modport master (
    output in_cu_ena, in_start,
    input  out_busy, out_done, out_addr_vld, out_pass_last, out_cand_col,
           out_rb_read_addr, out_sw_read_addr1, out_sw_read_addr2,
           out_pe_ena, out_sw_mux, dbg_state
  );

  modport slave (
    input  in_cu_ena, in_start,
    output out_busy, out_done, out_addr_vld, out_pass_last, out_cand_col,
           out_rb_read_addr, out_sw_read_addr1, out_sw_read_addr2,
           out_pe_ena, out_sw_mux, dbg_state
  );
endinterface

// File: rtl/me_search_sequencer.sv
// Full-search ME control unit: sweeps j (inner), i, then candidate column c,
// with incrementally built addresses, then drains the PE pipeline. BLK_N >= 2.
module me_search_sequencer #(
  parameter int BLK_N = 16,
  parameter int SW_W  = 31
) (
  input logic                   in_clk,
  input logic                   in_rst,
  me_search_sequencer_if.slave  bus
);
  localparam int CAND_COLS = SW_W - BLK_N + 1;
  localparam int CW        = (CAND_COLS > 1) ? $clog2(CAND_COLS) : 1;
  localparam int JW        = (BLK_N > 1) ? $clog2(BLK_N) : 1;
  localparam int RB_AW     = $clog2(BLK_N * BLK_N);
  localparam int SW_AW     = $clog2(SW_W * SW_W);

  localparam logic [JW-1:0]    J_MAX   = JW'(BLK_N - 1);
  localparam logic [JW-1:0]    D_LAST  = JW'(BLK_N - 2);
  localparam logic [CW-1:0]    C_MAX   = CW'(CAND_COLS - 1);
  localparam logic [RB_AW-1:0] RB_STEP = RB_AW'(BLK_N);
  localparam logic [SW_AW-1:0] SW_STEP = SW_AW'(SW_W);
  localparam logic [SW_AW-1:0] SW2_OFS = SW_AW'(BLK_N * SW_W);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [JW-1:0]    j_q, j_d, i_q, i_d, drain_q, drain_d;
  logic [CW-1:0]    c_q, c_d;
  logic [SW_AW-1:0] ci_q, ci_d, sw1_q, sw1_d, sw2_q, sw2_d;
  logic [RB_AW-1:0] rb_q, rb_d;
  logic [BLK_N-1:0] pe_q, pe_d, mux_q, mux_d;
  logic             vld_q, vld_d, last_q, last_d, done_q, done_d;
  logic             sw2_ok;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    i_d     = i_q;
    c_d     = c_q;
    ci_d    = ci_q;
    drain_d = drain_q;
    rb_d    = rb_q;
    sw1_d   = sw1_q;
    sw2_d   = sw2_q;
    pe_d    = pe_q;
    mux_d   = mux_q;
    vld_d   = vld_q;
    last_d  = last_q;
    done_d  = done_q;
    sw2_ok  = 1'b0;
    if (bus.in_cu_ena) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_start) begin
            state_d = RUN;
            j_d     = '0;
            i_d     = '0;
            c_d     = '0;
            ci_d    = '0;
            rb_d    = '0;
            sw1_d   = '0;
            pe_d    = BLK_N'(1);
            mux_d   = BLK_N'(1);
            vld_d   = 1'b1;
          end
        end
        RUN: begin
          pe_d = (pe_q << 1) | BLK_N'(1);
          if (j_q != J_MAX) begin
            j_d   = j_q + JW'(1);
            rb_d  = rb_q + RB_STEP;
            sw1_d = sw1_q + SW_STEP;
            mux_d = (mux_q << 1) | BLK_N'(1);
          end else if (i_q != J_MAX) begin
            j_d   = '0;
            i_d   = i_q + JW'(1);
            ci_d  = ci_q + SW_AW'(1);
            rb_d  = RB_AW'(i_d);
            sw1_d = ci_d;
            mux_d = BLK_N'(1);
          end else if (c_q != C_MAX) begin
            j_d   = '0;
            i_d   = '0;
            c_d   = c_q + CW'(1);
            ci_d  = SW_AW'(c_d);
            rb_d  = '0;
            sw1_d = ci_d;
            mux_d = BLK_N'(1);
          end else begin
            // Addresses and candidate column hold through the drain.
            state_d = DRAIN;
            drain_d = '0;
            vld_d   = 1'b0;
            mux_d   = '0;
          end
        end
        DRAIN: begin
          pe_d = (pe_q << 1) | BLK_N'(1);
          if (drain_q == D_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            j_d     = '0;
            i_d     = '0;
            c_d     = '0;
            ci_d    = '0;
            drain_d = '0;
            rb_d    = '0;
            sw1_d   = '0;
            sw2_d   = '0;
            pe_d    = '0;
            mux_d   = '0;
          end else begin
            drain_d = drain_q + JW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      // Port 2 reads the row BLK_N below unless that row falls off the window.
      if (state_d == RUN) begin
        sw2_ok = (32'(j_d) + 32'(BLK_N)) <= 32'(SW_W - 1);
        sw2_d  = sw2_ok ? sw1_d + SW2_OFS : sw1_d;
        last_d = (i_d == J_MAX) && (j_d == J_MAX);
      end else begin
        last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      i_q     <= '0;
      c_q     <= '0;
      ci_q    <= '0;
      drain_q <= '0;
      rb_q    <= '0;
      sw1_q   <= '0;
      sw2_q   <= '0;
      pe_q    <= '0;
      mux_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      i_q     <= i_d;
      c_q     <= c_d;
      ci_q    <= ci_d;
      drain_q <= drain_d;
      rb_q    <= rb_d;
      sw1_q   <= sw1_d;
      sw2_q   <= sw2_d;
      pe_q    <= pe_d;
      mux_q   <= mux_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_busy          = (state_q != IDLE);
  assign bus.out_done          = done_q;
  assign bus.out_addr_vld      = vld_q;
  assign bus.out_pass_last     = last_q;
  assign bus.out_cand_col      = c_q;
  assign bus.out_rb_read_addr  = rb_q;
  assign bus.out_sw_read_addr1 = sw1_q;
  assign bus.out_sw_read_addr2 = sw2_q;
  assign bus.out_pe_ena        = pe_q;
  assign bus.out_sw_mux        = mux_q;
  assign bus.dbg_state         = state_q;
endmodule

// File: tb/tb_me_search_sequencer.sv
// Bench for me_search_sequencer: two instances (16/31 and 8/15) swept with random
// stalls and compared cycle by cycle against an index-based reference model.
module tb_me_search_sequencer;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  me_search_sequencer_if #(.BLK_N(16), .SW_W(31)) a_if ();
  me_search_sequencer_if #(.BLK_N(8),  .SW_W(15)) b_if ();

  me_search_sequencer #(.BLK_N(16), .SW_W(31)) dut_a (
    .in_clk(clk), .in_rst(rst_a), .bus(a_if.slave));
  me_search_sequencer #(.BLK_N(8), .SW_W(15)) dut_b (
    .in_clk(clk), .in_rst(rst_b), .bus(b_if.slave));

  typedef struct {
    int busy, done, vld, last, cand, rb, sw1, sw2, pe, mux;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic drive(input int which, input bit start, input bit ena, input bit rst);
    if (which == 0) begin
      a_if.in_start = start; a_if.in_cu_ena = ena; rst_a = rst;
    end else begin
      b_if.in_start = start; b_if.in_cu_ena = ena; rst_b = rst;
    end
  endtask

  task automatic sample(input int which, output obs_t o);
    if (which == 0) begin
      o.busy = 32'(a_if.out_busy);          o.done = 32'(a_if.out_done);
      o.vld  = 32'(a_if.out_addr_vld);      o.last = 32'(a_if.out_pass_last);
      o.cand = 32'(a_if.out_cand_col);      o.rb   = 32'(a_if.out_rb_read_addr);
      o.sw1  = 32'(a_if.out_sw_read_addr1); o.sw2  = 32'(a_if.out_sw_read_addr2);
      o.pe   = 32'(a_if.out_pe_ena);        o.mux  = 32'(a_if.out_sw_mux);
    end else begin
      o.busy = 32'(b_if.out_busy);          o.done = 32'(b_if.out_done);
      o.vld  = 32'(b_if.out_addr_vld);      o.last = 32'(b_if.out_pass_last);
      o.cand = 32'(b_if.out_cand_col);      o.rb   = 32'(b_if.out_rb_read_addr);
      o.sw1  = 32'(b_if.out_sw_read_addr1); o.sw2  = 32'(b_if.out_sw_read_addr2);
      o.pe   = 32'(b_if.out_pe_ena);        o.mux  = 32'(b_if.out_sw_mux);
    end
  endtask

  function automatic int ones(input int w);
    return (w >= 31) ? 32'h7fff_ffff : (1 << w) - 1;
  endfunction

  function automatic obs_t exp_idle(input int done);
    obs_t e = '{default: 0};
    e.done = done;
    return e;
  endfunction

  // Reference for sweep step k: indices by division, addresses by the plain formulas.
  function automatic obs_t exp_run(input int n, input int sw, input int k);
    obs_t e = '{default: 0};
    int c = k / (n * n);
    int i = (k / n) % n;
    int j = k % n;
    e.busy = 1; e.vld = 1; e.cand = c;
    e.rb   = j * n + i;
    e.sw1  = (c + i) + j * sw;
    e.sw2  = (j + n <= sw - 1) ? e.sw1 + n * sw : e.sw1;
    e.last = (i == n - 1 && j == n - 1) ? 1 : 0;
    e.pe   = ones((k + 1 < n) ? k + 1 : n);
    for (int p = 0; p < n; p++)
      if (p == 0 || j >= p) e.mux |= (1 << p);
    return e;
  endfunction

  function automatic obs_t exp_drain(input int n, input int cand, input int steps);
    obs_t e = '{default: 0};
    e.busy = 1; e.cand = cand - 1;
    e.pe   = ones((steps < n) ? steps : n);
    return e;
  endfunction

  task automatic compare(input string p, input obs_t o, input obs_t e, input bit chk_addr);
    check({p, "_busy"}, o.busy, e.busy);
    check({p, "_done"}, o.done, e.done);
    check({p, "_vld"},  o.vld,  e.vld);
    check({p, "_last"}, o.last, e.last);
    check({p, "_cand"}, o.cand, e.cand);
    check({p, "_pe"},   o.pe,   e.pe);
    check({p, "_mux"},  o.mux,  e.mux);
    if (chk_addr) begin
      check({p, "_rb"},  o.rb,  e.rb);
      check({p, "_sw1"}, o.sw1, e.sw1);
      check({p, "_sw2"}, o.sw2, e.sw2);
    end
  endtask

  // Hand-computed landmarks from the 16/31 and 8/15 geometries.
  task automatic spot(input int which, input int k, input obs_t o);
    if (which == 0) begin
      case (k)
        0:    begin check("a0_sw2", o.sw2, 496); check("a0_mux", o.mux, 1); check("a0_pe", o.pe, 1); end
        1:    begin check("a1_rb", o.rb, 16); check("a1_sw1", o.sw1, 31); check("a1_sw2", o.sw2, 527);
                    check("a1_mux", o.mux, 3); check("a1_pe", o.pe, 3); end
        16:   begin check("a16_rb", o.rb, 1); check("a16_sw1", o.sw1, 1); check("a16_mux", o.mux, 1); end
        255:  begin check("a255_rb", o.rb, 255); check("a255_sw1", o.sw1, 480);
                    check("a255_sw2", o.sw2, 480); check("a255_last", o.last, 1); end
        256:  begin check("a256_cand", o.cand, 1); check("a256_rb", o.rb, 0); check("a256_sw1", o.sw1, 1); end
        4095: check("a4095_sw1", o.sw1, 495);
        default: ;
      endcase
    end else begin
      case (k)
        63:  begin check("b63_sw1", o.sw1, 112); check("b63_sw2", o.sw2, 112); check("b63_last", o.last, 1); end
        511: begin check("b511_sw1", o.sw1, 119); check("b511_sw2", o.sw2, 119); end
        default: ;
      endcase
    end
  endtask

  task automatic run_sweep(input int which, input int n, input int sw, input int abort_at);
    logic [31:0] exp_q[$];
    obs_t o;
    int   cand, total, k, d, ph, steps, stall_left, vld_cnt, drain_cnt;
    bit   forced, ena, finished;
    cand = sw - n + 1; total = cand * n * n;
    k = 0; d = 0; ph = 0; steps = 1; stall_left = 0; vld_cnt = 0; drain_cnt = 0;
    forced = 0; finished = 0;
    for (int c = 0; c < cand; c++)
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) exp_q.push_back(32'(c + i + j * sw));

    drive(which, 1, 1, 0);
    tick();
    drive(which, 0, 1, 0);
    sample(which, o);
    compare("run", o, exp_run(n, sw, 0), 1);
    spot(which, 0, o);
    vld_cnt += o.vld;
    check("sb_sw1", o.sw1, int'(exp_q.pop_front()));

    for (int cyc = 0; cyc < 3 * total + 100 && !finished; cyc++) begin
      if (ph == 0 && k == abort_at) begin
        drive(which, 0, 1, 1);
        tick();
        drive(which, 0, 1, 0);
        sample(which, o);
        compare("abort", o, exp_idle(0), 1);
        for (int t = 0; t < 20; t++) begin
          tick();
          sample(which, o);
          compare("post_abort", o, exp_idle(0), 1);
        end
        finished = 1;
      end else begin
        if (which == 0 && abort_at < 0 && k == 100 && !forced) begin
          forced = 1; stall_left = 3;
        end
        if (stall_left > 0) begin
          ena = 0; stall_left--;
        end else begin
          ena = ($urandom_range(0, 7) != 0);
        end
        drive(which, (ph == 0 && k == 50), ena, 0);
        tick();
        if (ena) begin
          steps++;
          if (ph == 0) begin
            if (k < total - 1) k++;
            else begin ph = 1; d = 1; end
          end else if (ph == 1) begin
            if (d < n - 1) d++;
            else ph = 2;
          end
        end
        sample(which, o);
        if (ph == 0) begin
          compare("run", o, exp_run(n, sw, k), 1);
          spot(which, k, o);
          if (ena) begin
            vld_cnt += o.vld;
            if (exp_q.size() > 0) check("sb_sw1", o.sw1, int'(exp_q.pop_front()));
            else check("sb_underflow", 0, 1);
          end
        end else if (ph == 1) begin
          compare("drain", o, exp_drain(n, cand, steps), 0);
          if (ena) drain_cnt += (o.busy & ~o.vld);
        end else begin
          compare("done", o, exp_idle(1), 1);
          check("vld_cycles", vld_cnt, total);
          check("drain_cycles", drain_cnt, n - 1);
          check("sb_left", exp_q.size(), 0);
          drive(which, 0, 1, 0);
          tick();
          sample(which, o);
          compare("after_done", o, exp_idle(0), 1);
          finished = 1;
        end
      end
    end
    check("sweep_finished", int'(finished), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    drive(0, 1, 1, 1);
    drive(1, 1, 1, 1);
    for (int t = 0; t < 3; t++) begin
      tick();
      sample(0, o);
      compare("in_reset", o, exp_idle(0), 1);
    end
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    tick();
    sample(0, o);
    compare("reset_a", o, exp_idle(0), 1);
    check("reset_state_a", int'(a_if.dbg_state), 0);
    sample(1, o);
    compare("reset_b", o, exp_idle(0), 1);

    run_sweep(0, 16, 31, 2000);
    run_sweep(0, 16, 31, -1);
    run_sweep(1, 8, 15, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
